// File: rtl/counter_pkg.sv
// Shared encodings for the counter bank: counting mode and count direction.
package counter_pkg;

    // Behaviour when a channel passes its terminal value
    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    // Count direction as presented on the dir inputs
    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage : counter_pkg

// File: rtl/counter_chan.sv
// One counter channel.
// Holds the count, its terminal value (top) and its wrap/saturate mode.
// tc and ovf are registered. A configuration write takes effect on the
// following cycle; the count update in the same cycle still uses the old
// top and mode.
module counter_chan
    import counter_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enab,
    input  logic             dir,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_top,
    input  logic             cfg_sat,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_top;
    mode_e            r_mode;
    logic             r_tc;
    logic             r_ovf;

    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_term;

    // Next count and terminal-event detection; load beats enable beats hold
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_term    = 1'b0;
        if (load) begin
            // Clamp loaded values into the legal range 0..top
            if (cnt_in > r_top) begin
                w_cnt_nxt = r_top;
            end else begin
                w_cnt_nxt = cnt_in;
            end
        end else if (enab) begin
            if (dir == DIR_UP) begin
                // >= rather than == so a count left above a lowered top terminates
                if (r_cnt >= r_top) begin
                    w_term = 1'b1;
                    if (r_mode == MODE_SAT) begin
                        w_cnt_nxt = r_top;
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + ONE;
                end
            end else begin
                if (r_cnt == '0) begin
                    w_term = 1'b1;
                    if (r_mode == MODE_SAT) begin
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_top;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - ONE;
                end
            end
        end else begin
            w_cnt_nxt = r_cnt;
            w_term    = 1'b0;
        end
    end

    // Channel state registers; a terminal event outranks a sticky-flag clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_top  <= '1;
            r_mode <= MODE_WRAP;
            r_tc   <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_tc  <= w_term;
            r_ovf <= w_term | (r_ovf & ~ovf_clr);
            if (cfg_we) begin
                r_top  <= cfg_top;
                r_mode <= mode_e'(cfg_sat);
            end
        end
    end

    assign cnt = r_cnt;
    assign tc  = r_tc;
    assign ovf = r_ovf;

endmodule : counter_chan

// File: rtl/counter_bank.sv
// Bank of NCH independent up/down counters.
// Each channel has its own programmable terminal value and wrap/saturate mode.
// This level only decodes the configuration write into a per-channel strobe.
// A cfg_ch value with no matching channel selects nothing.
module counter_bank
    import counter_pkg::*;
#(
    parameter  int WIDTH = 5,
    parameter  int NCH   = 4,
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       load,
    input  logic [NCH-1:0]       enab,
    input  logic [NCH-1:0]       dir,
    input  logic [NCH*WIDTH-1:0] cnt_in,
    input  logic                 cfg_we,
    input  logic [CHW-1:0]       cfg_ch,
    input  logic [WIDTH-1:0]     cfg_top,
    input  logic                 cfg_sat,
    input  logic [NCH-1:0]       ovf_clr,
    output logic [NCH*WIDTH-1:0] cnt_out,
    output logic [NCH-1:0]       tc,
    output logic [NCH-1:0]       ovf
);

    logic [NCH-1:0] w_cfg_we;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        assign w_cfg_we[g] = cfg_we & (cfg_ch == CHW'(g));

        counter_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .load    (load[g]),
            .enab    (enab[g]),
            .dir     (dir[g]),
            .cnt_in  (cnt_in[g*WIDTH +: WIDTH]),
            .cfg_we  (w_cfg_we[g]),
            .cfg_top (cfg_top),
            .cfg_sat (cfg_sat),
            .ovf_clr (ovf_clr[g]),
            .cnt     (cnt_out[g*WIDTH +: WIDTH]),
            .tc      (tc[g]),
            .ovf     (ovf[g])
        );
    end

endmodule : counter_bank

// File: tb/tb_counter_bank.sv
// Self-checking bench for counter_bank (WIDTH=5, NCH=4): table vectors on
// channel 0, directed corner sequences, then randomized traffic against a
// behavioural model.
module tb_counter_bank;

    localparam int W = 5;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   load, enab, dir, ovf_clr;
    logic [N*W-1:0] cnt_in;
    logic           cfg_we;
    logic [1:0]     cfg_ch;
    logic [W-1:0]   cfg_top;
    logic           cfg_sat;
    logic [N*W-1:0] cnt_out;
    logic [N-1:0]   tc, ovf;

    always #5 clk = ~clk;

    counter_bank #(.WIDTH(W), .NCH(N)) dut (
        .clk(clk), .rst(rst), .load(load), .enab(enab), .dir(dir),
        .cnt_in(cnt_in), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_top(cfg_top),
        .cfg_sat(cfg_sat), .ovf_clr(ovf_clr), .cnt_out(cnt_out), .tc(tc), .ovf(ovf)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, one entry per channel
    int m_cnt[N];
    int m_top[N];
    int m_sat[N];
    int m_tc[N];
    int m_ovf[N];

    typedef struct {
        logic       ld;
        logic       en;
        logic       up;
        logic       clr;
        logic [4:0] din;
        int         e_cnt;
        int         e_tc;
        int         e_ovf;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] c(input int i);
        return 32'(cnt_out[i*W +: W]);
    endfunction

    // Advance the model by one clock using the inputs currently driven
    task automatic m_step();
        for (int i = 0; i < N; i++) begin
            int term;
            int din;
            term = 0;
            din  = int'(cnt_in[i*W +: W]);
            if (rst) begin
                m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; m_top[i] = 31; m_sat[i] = 0;
            end else begin
                if (load[i]) begin
                    m_cnt[i] = (din < m_top[i]) ? din : m_top[i];
                end else if (enab[i] && dir[i]) begin
                    if (m_cnt[i] >= m_top[i]) begin
                        term = 1;
                        m_cnt[i] = m_sat[i] ? m_top[i] : 0;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end else if (enab[i]) begin
                    if (m_cnt[i] == 0) begin
                        term = 1;
                        m_cnt[i] = m_sat[i] ? 0 : m_top[i];
                    end else begin
                        m_cnt[i] = m_cnt[i] - 1;
                    end
                end
                m_tc[i] = term;
                if (term != 0) m_ovf[i] = 1;
                else if (ovf_clr[i]) m_ovf[i] = 0;
                if (cfg_we && int'(cfg_ch) == i) begin
                    m_top[i] = int'(cfg_top);
                    m_sat[i] = int'(cfg_sat);
                end
            end
        end
    endtask

    task automatic chk_all();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("model_cnt%0d", i), c(i), 32'(m_cnt[i]));
            chk($sformatf("model_tc%0d", i), 32'(tc[i]), 32'(m_tc[i]));
            chk($sformatf("model_ovf%0d", i), 32'(ovf[i]), 32'(m_ovf[i]));
        end
    endtask

    // One clock: update the model, let the edge pass, sample, compare
    task automatic cycle();
        m_step();
        @(posedge clk);
        #1;
        chk_all();
    endtask

    task automatic idle();
        rst = 1'b0; load = '0; enab = '0; dir = '0; cnt_in = '0;
        cfg_we = 1'b0; cfg_ch = 2'd0; cfg_top = 5'd0; cfg_sat = 1'b0; ovf_clr = '0;
    endtask

    task automatic cfg(input int ch, input int top, input logic sat);
        idle();
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_top = 5'(top); cfg_sat = sat;
        cycle();
        idle();
    endtask

    initial begin
        int pulses;
        int e37[7];

        //             ld    en    up    clr   din    cnt tc ovf
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd30, 30, 0, 0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd0,  31, 0, 0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd0,   0, 1, 1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,   0, 0, 1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  31, 1, 1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  31, 0, 0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  30, 0, 0};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd7,   7, 0, 0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 5'd0,   6, 0, 0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0,   0, 0, 0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 5'd0,  31, 1, 1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd5,   5, 0, 0};
        e37 = '{4, 3, 2, 1, 0, 5, 4};

        // Reset state
        idle(); rst = 1'b1;
        cycle();
        for (int i = 0; i < N; i++) begin
            chk("reset_cnt", c(i), 32'd0);
            chk("reset_tc", 32'(tc[i]), 32'd0);
            chk("reset_ovf", 32'(ovf[i]), 32'd0);
        end

        // Table vectors on channel 0 (top=31, wrap)
        for (int k = 0; k < 12; k++) begin
            idle();
            load[0] = tbl[k].ld; enab[0] = tbl[k].en; dir[0] = tbl[k].up;
            ovf_clr[0] = tbl[k].clr; cnt_in[4:0] = tbl[k].din;
            cycle();
            chk($sformatf("tbl%0d_cnt", k), c(0), 32'(tbl[k].e_cnt));
            chk($sformatf("tbl%0d_tc", k), 32'(tc[0]), 32'(tbl[k].e_tc));
            chk($sformatf("tbl%0d_ovf", k), 32'(ovf[0]), 32'(tbl[k].e_ovf));
        end

        // Free-running wrap after reset: 0..31, 0, 1
        idle(); rst = 1'b1; cycle(); idle();
        enab[0] = 1'b1; dir[0] = 1'b1;
        for (int k = 0; k < 33; k++) begin
            cycle();
            chk("wrap_cnt", c(0), 32'((k + 1) % 32));
            chk("wrap_tc", 32'(tc[0]), 32'(k == 31));
        end
        chk("wrap_ovf", 32'(ovf[0]), 32'd1);

        // Saturate at top=9; clear while the event repeats keeps ovf set
        cfg(1, 9, 1'b1);
        enab[1] = 1'b1; dir[1] = 1'b1; pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (k == 11) ovf_clr[1] = 1'b1;
            cycle();
            chk("sat_cnt", c(1), 32'((k + 1 < 9) ? k + 1 : 9));
            pulses += int'(tc[1]);
        end
        chk("sat_pulses", 32'(pulses), 32'd3);
        chk("sat_ovf_kept", 32'(ovf[1]), 32'd1);
        idle(); ovf_clr[1] = 1'b1; cycle();
        chk("sat_ovf_clr", 32'(ovf[1]), 32'd0);

        // Clamped load then down-count wrapping to top=5
        cfg(2, 5, 1'b0);
        load[2] = 1'b1; cnt_in[10 +: 5] = 5'd20; cycle();
        chk("clamp_load", c(2), 32'd5);
        idle(); enab[2] = 1'b1; dir[2] = 1'b0;
        for (int k = 0; k < 7; k++) begin
            cycle();
            chk("down_cnt", c(2), 32'(e37[k]));
            chk("down_tc", 32'(tc[2]), 32'(k == 5));
        end

        // Lowering top under the count in the same cycle as an up-count
        idle(); load[3] = 1'b1; cnt_in[15 +: 5] = 5'd12; cycle();
        chk("ch3_load", c(3), 32'd12);
        idle(); enab[3] = 1'b1; dir[3] = 1'b1;
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_top = 5'd7; cfg_sat = 1'b0;
        cycle();
        chk("oldtop_cnt", c(3), 32'd13);
        chk("oldtop_tc", 32'(tc[3]), 32'd0);
        cfg_we = 1'b0; cycle();
        chk("newtop_cnt", c(3), 32'd0);
        chk("newtop_tc", 32'(tc[3]), 32'd1);

        // Load beats enable
        idle(); load[0] = 1'b1; enab[0] = 1'b1; dir[0] = 1'b1; cnt_in[4:0] = 5'd3;
        cycle();
        chk("ld_en_cnt", c(0), 32'd3);
        chk("ld_en_tc", 32'(tc[0]), 32'd0);

        // Reset overrides everything and restores top=31
        idle(); rst = 1'b1; load = '1; enab = '1; dir = '1; cnt_in = '1; ovf_clr = '1;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_top = 5'd2;
        cycle();
        for (int i = 0; i < N; i++) begin
            chk("rst_ovr_cnt", c(i), 32'd0);
            chk("rst_ovr_ovf", 32'(ovf[i]), 32'd0);
        end
        idle(); load = '1; cnt_in = '1; cycle();
        for (int i = 0; i < N; i++) chk("rst_top31", c(i), 32'd31);

        // top=0: every enabled cycle is terminal, count stays 0
        cfg(0, 0, 1'b0);
        enab[0] = 1'b1; dir[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) dir[0] = 1'b0;
            cycle();
            chk("top0_cnt", c(0), 32'd0);
            chk("top0_tc", 32'(tc[0]), 32'd1);
        end

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            rst     = ($urandom_range(0, 63) == 0);
            load    = 4'($urandom & $urandom & $urandom);
            enab    = 4'($urandom);
            dir     = 4'($urandom);
            cnt_in  = 20'($urandom);
            cfg_we  = ($urandom_range(0, 5) == 0);
            cfg_ch  = 2'($urandom);
            cfg_top = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 2)) : 5'($urandom);
            cfg_sat = 1'($urandom);
            ovf_clr = 4'($urandom & $urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_counter_bank

// File: doc/counter_bank.md
COUNTER_BANK -- requirements
Module: counter_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 5, counter width per channel in bits (>=2).
REQ-002 SHALL have parameter NCH, default 4, number of independent channels (>=1).
REQ-003 SHALL derive local constant CHW = max(1, clog2(NCH)), the channel-select width.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port load  input  NCH  per-channel load strobe.
REQ-007 SHALL have port enab  input  NCH  per-channel count enable.
REQ-008 SHALL have port dir  input  NCH  per-channel direction, 1 = up, 0 = down.
REQ-009 SHALL have port cnt_in  input  NCH*WIDTH  load values, channel i at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port cfg_we  input  1  configuration write strobe.
REQ-011 SHALL have port cfg_ch  input  CHW  channel addressed by cfg_we.
REQ-012 SHALL have port cfg_top  input  WIDTH  new terminal value (count range 0..top).
REQ-013 SHALL have port cfg_sat  input  1  new mode, 1 = saturate, 0 = wrap.
REQ-014 SHALL have port ovf_clr  input  NCH  per-channel sticky-flag clear.
REQ-015 SHALL have port cnt_out  output  NCH*WIDTH  registered counts, same packing as cnt_in.
REQ-016 SHALL have port tc  output  NCH  registered one-cycle terminal-count pulse.
REQ-017 SHALL have port ovf  output  NCH  registered sticky overflow/underflow flag.

Function
REQ-018 SHALL give each channel i a registered top[i] and sat[i], written only when cfg_we=1 and cfg_ch=i; cfg_ch >= NCH SHALL be ignored.
REQ-019 SHALL apply priority per channel: rst > load > enab > hold.
REQ-020 On load, SHALL set cnt to min(cnt_in slice, top[i]), tc=0; ovf unchanged.
REQ-021 On enab, dir=1, cnt < top: cnt+1; dir=0, cnt > 0: cnt-1; tc=0.
REQ-022 On enab, dir=1, cnt >= top: wrap mode cnt=0, saturate mode cnt=top; tc=1 and ovf=1 in both modes.
REQ-023 On enab, dir=0, cnt=0: wrap mode cnt=top, saturate mode cnt=0; tc=1 and ovf=1 in both modes.
REQ-024 SHALL assert tc on the same edge as the count update causing it, for exactly one cycle unless the event repeats (saturate with enab held gives tc every cycle).
REQ-025 SHALL deassert tc in any cycle without a terminal event, including load and hold cycles.
REQ-026 A cfg write coinciding with counting on the same channel SHALL use the old top/sat for that cycle; new values apply from the next cycle.
REQ-027 If top is lowered below the current count, cnt SHALL be unchanged until the next load or enab; the next up-count is then a terminal event (REQ-022), and the next down-count decrements normally.
REQ-028 ovf_clr[i] SHALL clear ovf[i]; a simultaneous set event SHALL win (ovf stays 1).
REQ-029 top=0 SHALL be legal: every enabled cycle is a terminal event and cnt stays 0.
REQ-030 Channels SHALL be fully independent; no cross-channel combinational paths.

Reset
REQ-031 On rst, SHALL set every cnt to 0, tc to 0, ovf to 0, top to all-ones, and sat to 0 (wrap), which is plain free-running WIDTH-bit counter behaviour.
REQ-032 rst SHALL override load, enab, cfg_we and ovf_clr in the same cycle; reset mid-count SHALL discard all state.

Structure
REQ-033 SHALL place mode encodings (MODE_WRAP=0, MODE_SAT=1) and direction encodings (DIR_DOWN=0, DIR_UP=1) in shared package counter_pkg.
REQ-034 SHALL implement one channel as sub-module counter_chan (cnt, top, sat, tc, ovf), instantiated NCH times by a generate loop; config decode SHALL sit in counter_bank.

Verification (WIDTH=5, NCH=4)
REQ-035 Reset, enab[0]=1, dir=1 for 33 cycles: cnt0 goes 0..31, 0, 1; tc[0]=1 only on the 31->0 update; ovf[0]=1.
REQ-036 cfg ch1 top=9 sat=1, up-count from 0 for 12 cycles: cnt1 holds 9; tc[1]=1 on the 3 cycles at 9; ovf_clr[1] with enab still high keeps ovf[1]=1.
REQ-037 cfg ch2 top=5 wrap, load 20: cnt2=5; dir=0 for 7 cycles: 4,3,2,1,0,5,4 with tc[2]=1 on the 0->5 update.
REQ-038 ch3 at 12, write top=7 the same cycle as an up-count: cnt3=13; next up-count gives cnt3=0 with tc[3]=1.
REQ-039 load and enab both high on ch0 with cnt_in=3: cnt0=3, tc[0]=0; rst asserted with load high: all cnt=0, top=31.
